// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if
//
// Signal bundle for the load/store unit controller. It carries three groups:
//   req_*   : access request from the execute stage (valid/ready handshake)
//   mem_*   : single-outstanding request/acknowledge data-memory port
//   wb_*    : load result towards the register-file write path
//   fault*  : fault pulse and the address that caused it
//
// Modports:
//   master : the controller's view. It masters the memory port, answers the
//            execute stage and drives the write-back and fault outputs.
//   slave  : the environment's view (execute stage + data memory + register
//            file). It is the exact mirror of master.
// ---------------------------------------------------------------------------
interface lsu_ctrl_if;

    // Execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    // Data-memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Write-back and fault reporting
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rd, wb_data,
        output fault, fault_addr
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rd, wb_data,
        input  fault, fault_addr
    );

endinterface : lsu_ctrl_if

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store unit controller for the RV32I core. Accepts one load or store
// at a time from the execute stage, issues it on a single-outstanding
// request/acknowledge data-memory port with byte-lane steering, extends the
// returned load data and hands it to the register-file write path. Illegal
// funct3 codes and memory timeouts raise a one-cycle fault pulse.
//
// Parameters:
//   TIMEOUT_W : width of the wait-cycle counter. An access is abandoned
//               after 2**TIMEOUT_W cycles of mem_req without mem_ack.
//
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   lsu   : lsu_ctrl_if.master (request, memory, write-back, fault groups)
//
// Optional feature:
//   MISALIGN_TRAP_EN : when defined, LH/LHU/SH with addr[0]=1 and LW/SW with
//                      addr[1:0]!=0 fault instead of being issued. When not
//                      defined, such accesses are silently aligned (halfword
//                      uses addr[1] only, word ignores addr[1:0]).
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.master lsu
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // funct3 encodings; bits [1:0] give the access size, bit 2 = unsigned load
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    state_t                 state;
    logic [TIMEOUT_W-1:0]   wait_cnt;

    // Access context captured at accept time
    logic                   we_q;
    logic [2:0]             funct3_q;
    logic [31:0]            addr_q;
    logic [4:0]             rd_q;

    // Registered outputs
    logic                   mem_req_q;
    logic [3:0]             mem_be_q;
    logic [31:0]            mem_wdata_q;
    logic                   wb_valid_q;
    logic [4:0]             wb_rd_q;
    logic [31:0]            wb_data_q;
    logic                   fault_q;
    logic [31:0]            fault_addr_q;

    // Request decode (combinational, from the live request inputs)
    logic [1:0]             req_off;
    logic                   req_legal;
    logic                   req_misalign;
    logic [3:0]             req_be;
    logic [31:0]            req_wdata;

    // Load extraction (combinational, from the latched context)
    logic [1:0]             off_q;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [31:0]            ld_ext;

    assign req_off = lsu.req_addr[1:0];
    assign off_q   = addr_q[1:0];

    // -----------------------------------------------------------------------
    // Request decode: legality, optional misalignment and store lane steering
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements leaves it unassigned and no latch forms.
        req_legal    = 1'b0;
        req_misalign = 1'b0;
        req_be       = 4'b0000;
        req_wdata    = 32'd0;

        case (lsu.req_funct3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_BU, F3_HU:     req_legal = !lsu.req_we;   // unsigned forms are load-only
            default:          req_legal = 1'b0;
        endcase

`ifdef MISALIGN_TRAP_EN
        case (lsu.req_funct3[1:0])
            SZ_H:    req_misalign = req_off[0];
            SZ_B:    req_misalign = 1'b0;
            default: req_misalign = (req_off != 2'b00);
        endcase
`endif

        // Loads read the whole word, so enables and write data stay zero.
        if (lsu.req_we) begin
            case (lsu.req_funct3[1:0])
                SZ_B: begin
                    req_be    = 4'b0001 << req_off;
                    req_wdata = {4{lsu.req_wdata[7:0]}};
                end
                SZ_H: begin
                    // Only off[1] selects the half; off[0] is either trapped
                    // or dropped, which silently aligns the access.
                    req_be    = 4'b0011 << {req_off[1], 1'b0};
                    req_wdata = {2{lsu.req_wdata[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = lsu.req_wdata;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Load extraction and sign/zero extension
    // -----------------------------------------------------------------------
    always_comb begin
        ld_byte = lsu.mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = lsu.mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {24'd0, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {16'd0, ld_half};
            default: ld_ext = lsu.mem_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Asynchronous clear also drops mem_req immediately, abandoning
            // any access in flight without a write-back or fault.
            state        <= IDLE;
            wait_cnt     <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            rd_q         <= 5'd0;
            mem_req_q    <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here updates from values sampled before the clock edge.
            // Pulse outputs default low and are raised for a single cycle.
            wb_valid_q <= 1'b0;
            fault_q    <= 1'b0;

            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        if (!req_legal || req_misalign) begin
                            // Rejected at accept: report and stay in IDLE.
                            fault_q      <= 1'b1;
                            fault_addr_q <= lsu.req_addr;
                        end else begin
                            we_q        <= lsu.req_we;
                            funct3_q    <= lsu.req_funct3;
                            addr_q      <= lsu.req_addr;
                            rd_q        <= lsu.req_rd;
                            mem_req_q   <= 1'b1;
                            mem_be_q    <= req_be;
                            mem_wdata_q <= req_wdata;
                            wait_cnt    <= '0;
                            state       <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    // An ack in the last permitted cycle still completes the
                    // access, so it is tested before the timeout.
                    if (lsu.mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            state <= IDLE;
                        end else begin
                            wb_data_q  <= ld_ext;
                            wb_rd_q    <= rd_q;
                            wb_valid_q <= (rd_q != 5'd0);  // x0 is never written
                            state      <= RESP;
                        end
                    end else if (wait_cnt == '1) begin
                        mem_req_q    <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_addr_q <= addr_q;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // wb_valid is high during this one cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output wiring
    // -----------------------------------------------------------------------
    assign lsu.req_ready  = (state == IDLE);
    assign lsu.mem_req    = mem_req_q;
    assign lsu.mem_we     = we_q;
    assign lsu.mem_addr   = {addr_q[31:2], 2'b00};
    assign lsu.mem_be     = mem_be_q;
    assign lsu.mem_wdata  = mem_wdata_q;
    assign lsu.wb_valid   = wb_valid_q;
    assign lsu.wb_rd      = wb_rd_q;
    assign lsu.wb_data    = wb_data_q;
    assign lsu.fault      = fault_q;
    assign lsu.fault_addr = fault_addr_q;

endmodule : lsu_ctrl

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Self-checking bench for lsu_ctrl built with TIMEOUT_W = 3 (timeout after
// 8 cycles). A table of directed accesses with hand-computed expectations is
// applied first, followed by a reset-in-flight sequence and a run of random
// accesses whose expectations come from a byte-level reference model.
// Honours MISALIGN_TRAP_EN in both the table and the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_ctrl;

    localparam int TW   = 3;
    localparam int TMO  = 1 << TW;   // cycles mem_req may stay high
    localparam int NRND = 60;

    typedef struct {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          delay;      // wait cycles before ack; >= TMO means never
        logic [31:0] rdata;
        logic        exp_fault;  // rejected at accept
        logic [31:0] exp_addr;   // mem_addr
        logic [3:0]  exp_be;     // store byte enables
        logic [31:0] exp_wdata;  // store lane data
        logic [31:0] exp_wb;     // load result
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input int delay,
                                input logic [31:0] rdata, input logic flt,
                                input logic [31:0] eaddr, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] ewb);
        vec_t v;
        v.we = we; v.funct3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.delay = delay; v.rdata = rdata; v.exp_fault = flt; v.exp_addr = eaddr;
        v.exp_be = be; v.exp_wdata = ewd; v.exp_wb = ewb;
        return v;
    endfunction

    // Reference model: works in bytes and plain integer arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        int     size;
        int     off;
        int     eff;
        bit     legal;
        bit     mis;
        longint val;
        longint word;
        r    = v;
        size = (v.funct3[1:0] == 2'd0) ? 1 : (v.funct3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(v.addr % 4);
        if (v.we) legal = (v.funct3 inside {3'd0, 3'd1, 3'd2});
        else      legal = (v.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
        mis = (off % size) != 0;
`else
        mis = 1'b0;
`endif
        r.exp_fault = !legal || mis;
        r.exp_addr  = v.addr - (v.addr % 4);
        eff         = off - (off % size);
        r.exp_be    = 4'd0;
        r.exp_wdata = 32'd0;
        r.exp_wb    = 32'd0;
        if (v.we) begin
            r.exp_be = 4'(((1 << size) - 1) << eff);
            val      = longint'(v.wdata) % (64'd1 << (8 * size));
            word     = 0;
            for (int k = 0; k < 4 / size; k++) word += val << (8 * size * k);
            r.exp_wdata = word[31:0];
        end else begin
            val = (longint'(v.rdata) >> (8 * eff)) % (64'd1 << (8 * size));
            if (size < 4 && !v.funct3[2] && val >= (64'd1 << (8 * size - 1)))
                val = val - (64'd1 << (8 * size));
            r.exp_wb = val[31:0];
        end
        return r;
    endfunction

    // Apply one access. Entered and left at #1 after a rising edge in IDLE.
    task automatic run_txn(input vec_t v);
        bit acked;
        acked = 1'b0;
        check("req_ready_before", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.funct3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_rd     = v.rd;
        @(posedge clk); #1;
        // Scramble request inputs so latching is exercised.
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_rd     = 5'($urandom);
        if (v.exp_fault) begin
            check("reject_fault", bus.fault, 1'b1);
            check("reject_fault_addr", bus.fault_addr, v.addr);
            check("reject_no_mem_req", bus.mem_req, 1'b0);
            check("reject_ready", bus.req_ready, 1'b1);
            @(posedge clk); #1;
            check("reject_fault_pulse_end", bus.fault, 1'b0);
            check("reject_still_no_req", bus.mem_req, 1'b0);
            return;
        end
        for (int k = 0; k < TMO; k++) begin
            check("access_mem_req", bus.mem_req, 1'b1);
            check("access_not_ready", bus.req_ready, 1'b0);
            check("access_mem_addr", bus.mem_addr, v.exp_addr);
            check("access_mem_we", bus.mem_we, v.we);
            if (v.we) begin
                check("access_mem_be", bus.mem_be, v.exp_be);
                check("access_mem_wdata", bus.mem_wdata, v.exp_wdata);
            end
            if (k == v.delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rdata;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (k == v.delay) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) begin
            check("timeout_fault", bus.fault, 1'b1);
            check("timeout_fault_addr", bus.fault_addr, v.addr);
            check("timeout_mem_req_drop", bus.mem_req, 1'b0);
            check("timeout_ready", bus.req_ready, 1'b1);
            check("timeout_no_wb", bus.wb_valid, 1'b0);
            @(posedge clk); #1;
            check("timeout_fault_pulse_end", bus.fault, 1'b0);
        end else if (v.we) begin
            check("store_mem_req_drop", bus.mem_req, 1'b0);
            check("store_ready_after_ack", bus.req_ready, 1'b1);
            check("store_no_wb", bus.wb_valid, 1'b0);
            check("store_no_fault", bus.fault, 1'b0);
        end else begin
            check("load_wb_valid", bus.wb_valid, (v.rd != 5'd0));
            check("load_wb_rd", bus.wb_rd, v.rd);
            check("load_wb_data", bus.wb_data, v.exp_wb);
            check("load_mem_req_drop", bus.mem_req, 1'b0);
            check("load_resp_not_ready", bus.req_ready, 1'b0);
            check("load_no_fault", bus.fault, 1'b0);
            @(posedge clk); #1;
            check("load_wb_pulse_end", bus.wb_valid, 1'b0);
            check("load_ready_after_resp", bus.req_ready, 1'b1);
        end
    endtask

    vec_t tbl[15];
    vec_t rv;

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_rd     = 5'd0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'd0;

        // we, f3, addr, wdata, rd, delay, rdata | fault, mem_addr, be, wdata, wb
        tbl[0]  = mk(0, 3'b000, 32'h103, 0, 5, 0, 32'h80AA_BBCC, 0, 32'h100, 4'b0000, 0, 32'hFFFF_FF80);
        tbl[1]  = mk(0, 3'b100, 32'h103, 0, 5, 0, 32'h80AA_BBCC, 0, 32'h100, 4'b0000, 0, 32'h0000_0080);
        tbl[2]  = mk(1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 0, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 0);
        tbl[3]  = mk(0, 3'b010, 32'h40, 0, 1, 99, 0, 0, 32'h40, 4'b0000, 0, 0);
`ifdef MISALIGN_TRAP_EN
        tbl[4]  = mk(0, 3'b010, 32'h1002, 0, 7, 1, 32'hDEAD_BEEF, 1, 32'h1000, 4'b0000, 0, 0);
        tbl[12] = mk(1, 3'b001, 32'h203, 32'h0000_BEEF, 0, 0, 0, 1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 0);
`else
        tbl[4]  = mk(0, 3'b010, 32'h1002, 0, 7, 1, 32'hDEAD_BEEF, 0, 32'h1000, 4'b0000, 0, 32'hDEAD_BEEF);
        tbl[12] = mk(1, 3'b001, 32'h203, 32'h0000_BEEF, 0, 0, 0, 0, 32'h200, 4'b1100, 32'hBEEF_BEEF, 0);
`endif
        tbl[5]  = mk(0, 3'b011, 32'h300, 0, 2, 0, 0, 1, 32'h300, 4'b0000, 0, 0);
        tbl[6]  = mk(0, 3'b001, 32'h10, 0, 0, 2, 32'h0000_8001, 0, 32'h10, 4'b0000, 0, 32'hFFFF_8001);
        tbl[7]  = mk(1, 3'b000, 32'h7, 32'h0000_0055, 0, 1, 0, 0, 32'h4, 4'b1000, 32'h5555_5555, 0);
        tbl[8]  = mk(0, 3'b101, 32'h22, 0, 3, 0, 32'h8001_7FFF, 0, 32'h20, 4'b0000, 0, 32'h0000_8001);
        tbl[9]  = mk(0, 3'b001, 32'h20, 0, 4, 0, 32'h1234_8765, 0, 32'h20, 4'b0000, 0, 32'hFFFF_8765);
        tbl[10] = mk(1, 3'b010, 32'h44, 32'hCAFE_F00D, 0, 7, 0, 0, 32'h44, 4'b1111, 32'hCAFE_F00D, 0);
        tbl[11] = mk(1, 3'b100, 32'h500, 32'h1, 0, 0, 0, 1, 32'h500, 4'b0000, 0, 0);
        tbl[13] = mk(0, 3'b000, 32'h101, 0, 31, 3, 32'h0000_7F00, 0, 32'h100, 4'b0000, 0, 32'h0000_007F);
        tbl[14] = mk(0, 3'b010, 32'h80, 0, 9, 0, 32'h1357_9BDF, 0, 32'h80, 4'b0000, 0, 32'h1357_9BDF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_be", bus.mem_be, 4'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_wb_rd", bus.wb_rd, 5'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_fault", bus.fault, 1'b0);
        check("rst_fault_addr", bus.fault_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 14; i++) run_txn(tbl[i]);

        // Reset during the second wait cycle of a load
        check("mid_rst_ready", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h80;
        bus.req_rd     = 5'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mid_rst_req_wait0", bus.mem_req, 1'b1);
        @(posedge clk); #1;
        check("mid_rst_req_wait1", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req_async", bus.mem_req, 1'b0);
        check("mid_rst_ready_async", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        check("mid_rst_no_wb", bus.wb_valid, 1'b0);
        check("mid_rst_no_fault", bus.fault, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_wb", bus.wb_valid, 1'b0);
        check("post_rst_no_fault", bus.fault, 1'b0);
        run_txn(tbl[14]);

        // Random accesses against the reference model
        for (int n = 0; n < NRND; n++) begin
            rv.we     = 1'($urandom);
            rv.funct3 = 3'($urandom_range(0, 7));
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.rd     = 5'($urandom_range(0, 31));
            rv.delay  = int'($urandom_range(0, 9));
            rv.rdata  = $urandom;
            run_txn(model(rv));
            if ($urandom_range(0, 1) == 1) begin
                // Idle cycle with a stray ack, which must be ignored
                bus.mem_ack = 1'($urandom);
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
                check("idle_no_mem_req", bus.mem_req, 1'b0);
                check("idle_no_wb", bus.wb_valid, 1'b0);
                check("idle_no_fault", bus.fault, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lsu_ctrl
